// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared state encoding and width helper for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Smallest r with 2**r >= value, never below 1 so every counter has a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set req bit at or above ptr, wrapping modulo NREQ.
// Purely combinational; no backpressure of its own.
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  always_comb begin
    logic [IW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter in front of a FIFO write port; one IDLE cycle per grant,
// beats pass combinationally while busy; fifo_full drops gnt and holds ownership and counters.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int W         = 8,
  parameter int MAX_BEATS = 16,
  parameter int IDLE_TO   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] din_flat,
  input  logic [NREQ-1:0]   last,
  output logic [NREQ-1:0]   gnt,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [W-1:0]      fifo_din,
  output logic              busy,
  output logic              err
);

  localparam int IW = clog2(NREQ);
  localparam int BW = clog2(MAX_BEATS + 1);
  localparam int DW = clog2(IDLE_TO + 1);

  state_t        state, state_nx;
  logic [IW-1:0] owner, owner_nx;
  logic [IW-1:0] ptr, ptr_nx;
  logic [BW-1:0] beat_cnt, beat_nx;
  logic [DW-1:0] idle_cnt, idle_nx;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          own_req;
  logic          own_last;
  logic [W-1:0]  own_din;
  logic          accept;
  logic          drop;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_din  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IW'(i)) begin
        own_req  = req[i];
        own_last = last[i];
        own_din  = din_flat[i*W +: W];
      end
    end
  end

  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    ptr_nx     = ptr;
    beat_nx    = beat_cnt;
    idle_nx    = idle_cnt;
    gnt        = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    busy       = 1'b0;
    err        = 1'b0;
    accept     = 1'b0;
    drop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nx = ST_BUSY;
          owner_nx = pick_idx;
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
          if (owner == IW'(i)) gnt[i] = !fifo_full;
        end
        accept = own_req && !fifo_full;
        if (accept) begin
          fifo_wr_en = 1'b1;
          fifo_din   = own_din;
        end
        // A stalled but requesting owner is not idle, and a stalled beat is not counted.
        if (own_req) begin
          idle_nx = '0;
          if (accept) begin
            if (own_last) begin
              drop = 1'b1;
            end else if (beat_cnt == BW'(MAX_BEATS - 1)) begin
              drop = 1'b1;
              err  = 1'b1;
            end else begin
              beat_nx = beat_cnt + BW'(1);
            end
          end
        end else if (idle_cnt == DW'(IDLE_TO - 1)) begin
          drop = 1'b1;
          err  = 1'b1;
        end else begin
          idle_nx = idle_cnt + DW'(1);
        end
        if (drop) begin
          state_nx = ST_IDLE;
          ptr_nx   = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
          beat_nx  = '0;
          idle_nx  = '0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      owner    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      ptr      <= ptr_nx;
      beat_cnt <= beat_nx;
      idle_cnt <= idle_nx;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: per-source beat queues feed the DUT, expected writes
// are queued in arbitration order and matched against every fifo_wr_en cycle.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  typedef struct packed {
    logic [1:0]   s;
    logic [W-1:0] d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] din_flat;
  logic [NREQ-1:0]   last;
  logic [NREQ-1:0]   gnt;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [W-1:0]      fifo_din;
  logic              busy;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t src_q[NREQ][$];
  wr_t   exp_q[$];
  int    wr_cyc[$];
  int    cyc = 0;
  int    err_seen = 0;

  logic [NREQ-1:0] o_gnt;
  logic            o_wr, o_busy, o_err;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .W         (W),
    .MAX_BEATS (16),
    .IDLE_TO   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din_flat   (din_flat),
    .last       (last),
    .gnt        (gnt),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    int  s;
    wr_t e;
    if (rst === 1'b1 && fifo_wr_en === 1'b1) begin
      s = -1;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) s = i;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got src %0d data %h, required no write", s, fifo_din);
      end else begin
        e = exp_q.pop_front();
        if (s != int'(e.s) || fifo_din !== e.d) begin
          n_fail++;
          $display("FAIL write_data: got src %0d data %h, required src %0d data %h",
                   s, fifo_din, e.s, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic load(input int s, input logic [W-1:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    src_q[s].push_back(b);
  endtask

  task automatic expect_wr(input int s, input logic [W-1:0] d);
    wr_t e;
    e.s = 2'(s);
    e.d = d;
    exp_q.push_back(e);
  endtask

  // One cycle per iteration: present queue heads, sample at negedge, retire accepted beats.
  task automatic pump(input int ncyc);
    logic [NREQ-1:0] acc;
    for (int c = 0; c < ncyc; c++) begin
      for (int s = 0; s < NREQ; s++) begin
        if (src_q[s].size() > 0) begin
          req[s]             = 1'b1;
          din_flat[s*W +: W] = src_q[s][0].d;
          last[s]            = src_q[s][0].l;
        end else begin
          req[s]             = 1'b0;
          din_flat[s*W +: W] = '0;
          last[s]            = 1'b0;
        end
      end
      @(negedge clk);
      acc    = gnt & req;
      o_gnt  = gnt;
      o_wr   = fifo_wr_en;
      o_busy = busy;
      o_err  = err;
      if (fifo_wr_en) wr_cyc.push_back(cyc);
      if (err) err_seen++;
      cyc++;
      @(posedge clk);
      #1;
      for (int s = 0; s < NREQ; s++) if (acc[s]) void'(src_q[s].pop_front());
    end
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: got %0d pending writes, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    req       = '1;
    last      = '1;
    din_flat  = {NREQ*W{1'b1}};
    fifo_full = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({gnt, fifo_wr_en, fifo_din, busy, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt %b wr %b din %h busy %b err %b, required all 0",
               gnt, fifo_wr_en, fifo_din, busy, err);
    end
    @(posedge clk);
    #1;
    req      = '0;
    last     = '0;
    din_flat = '0;
    rst      = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({gnt, busy, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got gnt %b busy %b err %b, required 0", gnt, busy, err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    load(1, 8'h11, 1'b0); load(1, 8'h22, 1'b0); load(1, 8'h33, 1'b1);
    expect_wr(1, 8'h11); expect_wr(1, 8'h22); expect_wr(1, 8'h33);
    pump(1);
    n_checks++;
    if (o_gnt !== 4'b0000 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_arb_latency: got gnt %b busy %b, required gnt 0000 busy 0", o_gnt, o_busy);
    end
    for (int k = 0; k < 3; k++) begin
      pump(1);
      n_checks++;
      if (o_gnt !== 4'b0010 || o_wr !== 1'b1) begin
        n_fail++;
        $display("FAIL single_beat%0d: got gnt %b wr %b, required gnt 0010 wr 1", k, o_gnt, o_wr);
      end
    end
    pump(1);
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: got busy %b, required 0", o_busy);
    end
    load(1, 8'hA1, 1'b1); load(2, 8'hA2, 1'b1);
    expect_wr(2, 8'hA2); expect_wr(1, 8'hA1);
    pump(2);
    n_checks++;
    if (o_gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ptr_rotate: got gnt %b, required 0100", o_gnt);
    end
    pump(3);
    check_drained("single");
  endtask

  task automatic test_round_robin();
    load(3, 8'h30, 1'b1);
    expect_wr(3, 8'h30);
    pump(3);
    wr_cyc.delete();
    load(0, 8'hB0, 1'b1); load(0, 8'hB4, 1'b1);
    load(1, 8'hB1, 1'b1); load(2, 8'hB2, 1'b1); load(3, 8'hB3, 1'b1);
    expect_wr(0, 8'hB0); expect_wr(1, 8'hB1); expect_wr(2, 8'hB2);
    expect_wr(3, 8'hB3); expect_wr(0, 8'hB4);
    pump(12);
    n_checks++;
    if (wr_cyc.size() != 5) begin
      n_fail++;
      $display("FAIL rr_write_count: got %0d, required 5", wr_cyc.size());
    end else begin
      for (int k = 1; k < 5; k++) begin
        n_checks++;
        if (wr_cyc[k] - wr_cyc[k-1] != 2) begin
          n_fail++;
          $display("FAIL rr_bubble%0d: got spacing %0d, required 2", k, wr_cyc[k] - wr_cyc[k-1]);
        end
      end
    end
    check_drained("rr");
  endtask

  task automatic test_backpressure();
    err_seen = 0;
    load(2, 8'hC1, 1'b0); load(2, 8'hC2, 1'b0); load(2, 8'hC3, 1'b0); load(2, 8'hC4, 1'b1);
    expect_wr(2, 8'hC1); expect_wr(2, 8'hC2); expect_wr(2, 8'hC3); expect_wr(2, 8'hC4);
    pump(1);
    for (int k = 0; k < 2; k++) begin
      pump(1);
      n_checks++;
      if (o_gnt !== 4'b0100 || o_wr !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_pre_beat%0d: got gnt %b wr %b, required gnt 0100 wr 1", k, o_gnt, o_wr);
      end
    end
    fifo_full = 1'b1;
    for (int k = 0; k < 10; k++) begin
      pump(1);
      n_checks++;
      if ({o_gnt, o_wr, o_busy, o_err} !== 7'b0000_0_1_0) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got gnt %b wr %b busy %b err %b, required 0000 0 1 0",
                 k, o_gnt, o_wr, o_busy, o_err);
      end
    end
    fifo_full = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pump(1);
      n_checks++;
      if (o_gnt !== 4'b0100 || o_wr !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_post_beat%0d: got gnt %b wr %b, required gnt 0100 wr 1", k, o_gnt, o_wr);
      end
    end
    pump(1);
    n_checks++;
    if (o_busy !== 1'b0 || err_seen != 0) begin
      n_fail++;
      $display("FAIL bp_end: got busy %b err count %0d, required busy 0 err count 0", o_busy, err_seen);
    end
    check_drained("bp");
  endtask

  task automatic test_max_beats();
    for (int k = 0; k < 16; k++) begin
      load(0, 8'hD0 + 8'(k), 1'b0);
      expect_wr(0, 8'hD0 + 8'(k));
    end
    load(0, 8'hE0, 1'b1);
    expect_wr(1, 8'hE1);
    expect_wr(0, 8'hE0);
    pump(1);
    for (int k = 1; k <= 16; k++) begin
      pump(1);
      n_checks++;
      if (o_wr !== 1'b1 || o_err !== (k == 16)) begin
        n_fail++;
        $display("FAIL max_beat%0d: got wr %b err %b, required wr 1 err %b", k, o_wr, o_err, k == 16);
      end
    end
    load(1, 8'hE1, 1'b1);
    pump(1);
    n_checks++;
    if (o_busy !== 1'b0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL max_idle_after: got busy %b err %b, required 0 0", o_busy, o_err);
    end
    pump(1);
    n_checks++;
    if (o_gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL max_ptr_rotate: got gnt %b, required 0010", o_gnt);
    end
    pump(3);
    check_drained("max");
  endtask

  task automatic test_idle_timeout();
    load(3, 8'hF3, 1'b0); load(0, 8'hF0, 1'b1);
    expect_wr(3, 8'hF3); expect_wr(0, 8'hF0);
    pump(1);
    pump(1);
    n_checks++;
    if (o_gnt !== 4'b1000 || o_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_first_beat: got gnt %b wr %b, required gnt 1000 wr 1", o_gnt, o_wr);
    end
    for (int k = 1; k <= 8; k++) begin
      pump(1);
      n_checks++;
      if ({o_wr, o_busy, o_err} !== {1'b0, 1'b1, k == 8}) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got wr %b busy %b err %b, required 0 1 %b",
                 k, o_wr, o_busy, o_err, k == 8);
      end
    end
    pump(1);
    n_checks++;
    if (o_busy !== 1'b0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_released: got busy %b err %b, required 0 0", o_busy, o_err);
    end
    pump(1);
    n_checks++;
    if (o_gnt !== 4'b0001 || o_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_next_owner: got gnt %b wr %b, required gnt 0001 wr 1", o_gnt, o_wr);
    end
    pump(1);
    check_drained("idle");
  endtask

  task automatic test_reset_mid_packet();
    load(1, 8'h51, 1'b0);
    expect_wr(1, 8'h51);
    pump(2);
    n_checks++;
    if (o_wr !== 1'b1 || o_gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL rstmid_beat1: got gnt %b wr %b, required gnt 0010 wr 1", o_gnt, o_wr);
    end
    req[1]          = 1'b1;
    din_flat[15:8]  = 8'h52;
    last[1]         = 1'b0;
    #2;
    n_checks++;
    if (busy !== 1'b1 || fifo_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got busy %b wr %b, required 1 1", busy, fifo_wr_en);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({gnt, fifo_wr_en, fifo_din, busy, err} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got gnt %b wr %b din %h busy %b err %b, required all 0",
               gnt, fifo_wr_en, fifo_din, busy, err);
    end
    req      = '0;
    last     = '0;
    din_flat = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    load(0, 8'h60, 1'b1); load(1, 8'h61, 1'b1);
    expect_wr(0, 8'h60); expect_wr(1, 8'h61);
    pump(2);
    n_checks++;
    if (o_gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL rstmid_ptr0: got gnt %b, required 0001", o_gnt);
    end
    pump(3);
    check_drained("rstmid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_max_beats();
    test_idle_timeout();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
